// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - AXI4-Lite initiator with one outstanding transaction
module axi_lite_master #(
   parameter int         ADDR_W = 32,
   parameter int         DATA_W = 32,
   parameter logic [2:0] PROT   = 3'b000
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_write,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [2:0]          m_axi_awprot,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic [2:0]          m_axi_arprot,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WAIT_B, S_READ, S_WAIT_R, S_RESP
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_wstrb;
   logic                  r_write;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic [DATA_W-1:0]     r_rsp_rdata;
   logic [1:0]            r_rsp_resp;

   logic w_cmd_fire, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire, w_rsp_fire;

   assign w_cmd_fire = cmd_valid && cmd_ready;
   assign w_aw_fire  = m_axi_awvalid && m_axi_awready;
   assign w_w_fire   = m_axi_wvalid && m_axi_wready;
   assign w_b_fire   = m_axi_bvalid && m_axi_bready;
   assign w_ar_fire  = m_axi_arvalid && m_axi_arready;
   assign w_r_fire   = m_axi_rvalid && m_axi_rready;
   assign w_rsp_fire = rsp_valid && rsp_ready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_cmd_fire) w_next = cmd_write ? S_WRITE : S_READ;
         S_WRITE:  if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = S_WAIT_B;
         S_WAIT_B: if (w_b_fire) w_next = S_RESP;
         S_READ:   if (w_ar_fire) w_next = S_WAIT_R;
         S_WAIT_R: if (w_r_fire) w_next = S_RESP;
         S_RESP:   if (w_rsp_fire) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Handshake outputs decode the state so an async reset drops them at once.
   always_comb begin
      cmd_ready     = aresetn && (r_state == S_IDLE);
      m_axi_awvalid = (r_state == S_WRITE) && !r_aw_done;
      m_axi_wvalid  = (r_state == S_WRITE) && !r_w_done;
      m_axi_bready  = (r_state == S_WAIT_B);
      m_axi_arvalid = (r_state == S_READ);
      m_axi_rready  = (r_state == S_WAIT_R);
      rsp_valid     = (r_state == S_RESP);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_write     <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
      end else begin
         if (w_cmd_fire) begin
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_write   <= cmd_write;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (w_aw_fire) r_aw_done <= 1'b1;
         if (w_w_fire)  r_w_done  <= 1'b1;
         if (w_b_fire) begin
            r_rsp_resp  <= m_axi_bresp;
            r_rsp_rdata <= '0;
         end
         if (w_r_fire) begin
            r_rsp_resp  <= m_axi_rresp;
            r_rsp_rdata <= m_axi_rdata;
         end
      end
   end

   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_resp     = r_rsp_resp;
   assign rsp_write    = r_write;
   assign m_axi_awaddr = r_addr;
   assign m_axi_araddr = r_addr;
   assign m_axi_awprot = PROT;
   assign m_axi_arprot = PROT;
   assign m_axi_wdata  = r_wdata;
   assign m_axi_wstrb  = r_wstrb;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - scoreboard bench for axi_lite_master with a delay-configurable slave
module tb_axi_lite_master;

   logic        aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic        aresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;

   axi_lite_master #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   typedef struct {
      logic        wr;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] ref_mem [16];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Slave model knobs and state; it drives its outputs on the falling edge.
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
   bit          rforce = 1'b0;
   logic [31:0] rforce_data = 32'h0;
   logic [31:0] exp_awaddr = 32'h0, exp_wdata = 32'h0;
   logic [3:0]  exp_wstrb = 4'h0;
   int          b_count = 0;
   logic [31:0] mem [16] = '{default: 32'h0};
   bit          aw_got, w_got, ar_got, b_armed, r_armed, aw_pend, w_pend, ar_pend;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;

   always @(negedge aclk) begin
      if (!aresetn) begin
         m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
         m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
         aw_got = 0; w_got = 0; ar_got = 0; b_armed = 0; r_armed = 0;
         aw_pend = 0; w_pend = 0; ar_pend = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
         if (aw_pend) chk("awvalid_held", 32'(m_axi_awvalid), 32'd1);
         if (w_pend)  chk("wvalid_held", 32'(m_axi_wvalid), 32'd1);
         if (ar_pend) chk("arvalid_held", 32'(m_axi_arvalid), 32'd1);
         m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
         if (m_axi_awvalid && !aw_got) begin
            if (aw_cnt >= aw_delay) begin
               m_axi_awready = 1; aw_got = 1; cap_awaddr = m_axi_awaddr;
            end else aw_cnt++;
         end
         if (m_axi_wvalid && !w_got) begin
            if (w_cnt >= w_delay) begin
               m_axi_wready = 1; w_got = 1; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
            end else w_cnt++;
         end
         if (m_axi_arvalid && !ar_got) begin
            if (ar_cnt >= ar_delay) begin
               m_axi_arready = 1; ar_got = 1; cap_araddr = m_axi_araddr;
            end else ar_cnt++;
         end
         aw_pend = m_axi_awvalid && !m_axi_awready;
         w_pend  = m_axi_wvalid && !m_axi_wready;
         ar_pend = m_axi_arvalid && !m_axi_arready;
         if (b_armed) begin
            m_axi_bvalid = 0; b_armed = 0; b_count++;
            chk("awaddr", cap_awaddr, exp_awaddr);
            chk("wdata", cap_wdata, exp_wdata);
            chk("wstrb", 32'(cap_wstrb), 32'(exp_wstrb));
            for (int k = 0; k < 4; k++)
               if (cap_wstrb[k]) mem[cap_awaddr[5:2]][8*k +: 8] = cap_wdata[8*k +: 8];
            aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end else if (aw_got && w_got && !m_axi_bvalid) begin
            if (b_cnt > b_delay) begin
               m_axi_bvalid = 1; m_axi_bresp = bresp_k;
            end else b_cnt++;
         end
         b_armed = m_axi_bvalid && m_axi_bready;
         if (r_armed) begin
            m_axi_rvalid = 0; r_armed = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
         end else if (ar_got && !m_axi_rvalid) begin
            if (r_cnt > r_delay) begin
               m_axi_rvalid = 1; m_axi_rresp = rresp_k;
               m_axi_rdata = rforce ? rforce_data : mem[cap_araddr[5:2]];
            end else r_cnt++;
         end
         r_armed = m_axi_rvalid && m_axi_rready;
      end
   end

   // Response monitor: a handshake seen here completes on the next rising edge.
   always @(negedge aclk) begin
      if (aresetn && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_write", 32'(rsp_write), 32'(e.wr));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
         end
      end
   end

   task automatic drive_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] er, input logic [1:0] eresp);
      exp_t e;
      @(posedge aclk); #1;
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      if (wr) begin exp_awaddr = addr; exp_wdata = data; exp_wstrb = strb; end
      e.wr = wr; e.rdata = wr ? 32'h0 : er; e.resp = eresp;
      sb.push_back(e);
   endtask

   task automatic wait_accept();
      int n = 0;
      forever begin
         @(negedge aclk);
         if (cmd_ready) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 0;
            return;
         end
      end
      @(posedge aclk); #1;
      cmd_valid = 0;
      chk("first_valid", 32'(cmd_write ? (m_axi_awvalid & m_axi_wvalid) : m_axi_arvalid), 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge aclk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("rsp_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(posedge aclk); #1;
   endtask

   task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] er, input logic [1:0] eresp);
      drive_cmd(wr, addr, data, strb, er, eresp);
      wait_accept();
      wait_done();
   endtask

   task automatic ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      for (int k = 0; k < 4; k++)
         if (strb[k]) ref_mem[addr[5:2]][8*k +: 8] = data[8*k +: 8];
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input logic [1:0] eresp);
      ref_write(addr, data, strb);
      run_cmd(1'b1, addr, data, strb, 32'h0, eresp);
   endtask

   task automatic rd(input logic [31:0] addr);
      run_cmd(1'b0, addr, 32'h0, 4'h0, ref_mem[addr[5:2]], 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b0, n;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 1;
      repeat (3) @(negedge aclk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}), 32'd0);
      chk("rst_readies", 32'({m_axi_bready, m_axi_rready}), 32'd0);
      chk("rst_awaddr", m_axi_awaddr, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      @(posedge aclk); #1;
      aresetn = 1;
      #1;
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("prot", 32'({m_axi_awprot, m_axi_arprot}), 32'd0);

      wr(32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
      run_cmd(1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
      wr(32'h4, 32'h0000CAFE, 4'h3, 2'b00);
      run_cmd(1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADCAFE, 2'b00);

      aw_delay = 5; w_delay = 0;
      b0 = b_count;
      wr(32'h8, 32'h11223344, 4'hF, 2'b00);
      chk("b_once_aw_stall", 32'(b_count - b0), 32'd1);
      aw_delay = 0; w_delay = 5;
      b0 = b_count;
      wr(32'hC, 32'h55667788, 4'hF, 2'b00);
      chk("b_once_w_stall", 32'(b_count - b0), 32'd1);
      w_delay = 0;
      run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 32'h11223344, 2'b00);

      bresp_k = 2'b11;
      wr(32'h10, 32'h0BADF00D, 4'hF, 2'b11);
      bresp_k = 2'b00;

      ar_delay = 3; r_delay = 4; rresp_k = 2'b10; rforce = 1; rforce_data = 32'hA5C30F96;
      run_cmd(1'b0, 32'h14, 32'h0, 4'h0, 32'hA5C30F96, 2'b10);
      ar_delay = 0; r_delay = 0; rresp_k = 2'b00; rforce = 0;

      rsp_ready = 0;
      drive_cmd(1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADCAFE, 2'b00);
      wait_accept();
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge aclk); n++; end
      chk("stall_rsp_arrived", 32'(rsp_valid), 32'd1);
      ref_write(32'h18, 32'hCAFEF00D, 4'hF);
      drive_cmd(1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00);
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rsp_rdata", rsp_rdata, 32'hDEADCAFE);
         chk("stall_aw_idle", 32'(m_axi_awvalid), 32'd0);
      end
      @(posedge aclk); #1;
      rsp_ready = 1;
      wait_accept();
      wait_done();
      rd(32'h18);

      b_delay = 20;
      drive_cmd(1'b1, 32'h3C, 32'h12345678, 4'hF, 32'h0, 2'b00);
      wait_accept();
      n = 0;
      while (!m_axi_bready && n < 50) begin @(negedge aclk); n++; end
      chk("reached_wait_b", 32'(m_axi_bready), 32'd1);
      #2;
      aresetn = 0;
      #1;
      chk("rst_mid_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}), 32'd0);
      chk("rst_mid_readies", 32'({m_axi_bready, m_axi_rready, cmd_ready}), 32'd0);
      chk("rst_mid_rsp_resp", 32'(rsp_resp), 32'd0);
      sb.delete();
      b_delay = 0;
      repeat (2) @(negedge aclk);
      @(posedge aclk); #1;
      aresetn = 1;
      #1;
      chk("post_rst_idle", 32'(cmd_ready), 32'd1);
      wr(32'h1C, 32'h600DD00D, 4'hF, 2'b00);
      rd(32'h1C);

      for (int i = 0; i < 6; i++) begin
         logic [31:0] a, d;
         logic [3:0]  s;
         a = 32'($urandom_range(0, 7)) << 2;
         d = $urandom;
         s = 4'($urandom_range(1, 15));
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
         r_delay = $urandom_range(0, 3);
         wr(a, d, s, 2'b00);
         rd(a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
